feature_scan_ctrl: RTL and testbench

//  Programmable 2-D traversal controller for the GCN feature/weight buffers; next generation of the

---
 rtl/feature_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_feature_scan_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_scan_ctrl.sv
// Programmable 2-D window traversal controller: walks a latched (rows x cols) window in
// row-major or column-major order and presents row/col indices plus a linear buffer address.
module feature_scan_ctrl #(
   parameter int FEATURE_ROWS = 6,
   parameter int FEATURE_COLS = 96,
   parameter int ROW_W        = $clog2(FEATURE_ROWS),
   parameter int COL_W        = $clog2(FEATURE_COLS),
   parameter int ADDR_W       = $clog2(FEATURE_ROWS * FEATURE_COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ROW_W-1:0]  cfg_last_row,
   input  logic [COL_W-1:0]  cfg_last_col,
   input  logic              cfg_col_major,
   input  logic              advance,
   output logic              busy,
   output logic [ROW_W-1:0]  row_idx,
   output logic [COL_W-1:0]  col_idx,
   output logic [ADDR_W-1:0] addr,
   output logic              row_last,
   output logic              col_last,
   output logic              done
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [ROW_W-1:0] MAX_ROW = ROW_W'(FEATURE_ROWS - 1);
   localparam logic [COL_W-1:0] MAX_COL = COL_W'(FEATURE_COLS - 1);

   state_t           state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] last_row_q, last_row_d;
   logic [COL_W-1:0] last_col_q, last_col_d;
   logic             col_major_q, col_major_d;
   logic             done_q, done_d;
   logic             at_last_row, at_last_col;

   assign at_last_row = (row_q == last_row_q);
   assign at_last_col = (col_q == last_col_q);

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      last_row_d  = last_row_q;
      last_col_d  = last_col_q;
      col_major_d = col_major_q;
      done_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d     = S_RUN;
               row_d       = '0;
               col_d       = '0;
               // Oversized requests clamp to the physical window so indices and addr stay in range.
               last_row_d  = (cfg_last_row > MAX_ROW) ? MAX_ROW : cfg_last_row;
               last_col_d  = (cfg_last_col > MAX_COL) ? MAX_COL : cfg_last_col;
               col_major_d = cfg_col_major;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               row_d   = '0;
               col_d   = '0;
            end else if (advance) begin
               if (at_last_row && at_last_col) begin
                  state_d = S_IDLE;
                  row_d   = '0;
                  col_d   = '0;
                  done_d  = 1'b1;
               end else if (col_major_q) begin
                  if (at_last_row) begin
                     row_d = '0;
                     col_d = col_q + 1'b1;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  if (at_last_col) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         last_row_q  <= '0;
         last_col_q  <= '0;
         col_major_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         last_row_q  <= last_row_d;
         last_col_q  <= last_col_d;
         col_major_q <= col_major_d;
         done_q      <= done_d;
      end
   end

   // Flags are qualified by busy so that idle/reset presents all-zero outputs.
   assign busy     = (state_q == S_RUN);
   assign row_idx  = row_q;
   assign col_idx  = col_q;
   assign addr     = ADDR_W'(row_q) * ADDR_W'(FEATURE_COLS) + ADDR_W'(col_q);
   assign row_last = busy && at_last_row;
   assign col_last = busy && at_last_col;
   assign done     = done_q;

endmodule

// File: tb/tb_feature_scan_ctrl.sv
// Randomized scoreboard bench for feature_scan_ctrl: stimulus pushes the expected element
// sequence of each scan, a negedge monitor pops and compares on every consumed element and done.
module tb_feature_scan_ctrl;

   localparam int ROWS   = 6;
   localparam int COLS   = 96;
   localparam int ROW_W  = $clog2(ROWS);
   localparam int COL_W  = $clog2(COLS);
   localparam int ADDR_W = $clog2(ROWS * COLS);

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [ROW_W-1:0]  cfg_last_row;
   logic [COL_W-1:0]  cfg_last_col;
   logic              cfg_col_major;
   logic              advance;
   logic              busy;
   logic [ROW_W-1:0]  row_idx;
   logic [COL_W-1:0]  col_idx;
   logic [ADDR_W-1:0] addr;
   logic              row_last;
   logic              col_last;
   logic              done;

   feature_scan_ctrl #(
      .FEATURE_ROWS(ROWS),
      .FEATURE_COLS(COLS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .cfg_last_row (cfg_last_row),
      .cfg_last_col (cfg_last_col),
      .cfg_col_major(cfg_col_major),
      .advance      (advance),
      .busy         (busy),
      .row_idx      (row_idx),
      .col_idx      (col_idx),
      .addr         (addr),
      .row_last     (row_last),
      .col_last     (col_last),
      .done         (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_done;
      int r;
      int c;
      int a;
      bit rl;
      bit cl;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks    = 0;
   int   n_fail      = 0;
   bit   expect_done = 1'b0;
   int   busy_cycles = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: enumerate the clamped window in the requested order, then a done marker.
   function automatic int push_scan(input int lr, input int lc, input bit cm);
      int nr = ((lr > ROWS - 1) ? ROWS - 1 : lr) + 1;
      int nc = ((lc > COLS - 1) ? COLS - 1 : lc) + 1;
      exp_t e;
      for (int o = 0; o < (cm ? nc : nr); o++) begin
         for (int i = 0; i < (cm ? nr : nc); i++) begin
            e.is_done = 1'b0;
            e.r  = cm ? i : o;
            e.c  = cm ? o : i;
            e.a  = e.r * COLS + e.c;
            e.rl = (e.r == nr - 1);
            e.cl = (e.c == nc - 1);
            sb_q.push_back(e);
         end
      end
      e = '{1'b1, 0, 0, 0, 1'b0, 1'b0};
      sb_q.push_back(e);
      return nr * nc;
   endfunction

   task automatic issue_start(input int lr, input int lc, input bit cm, output int n);
      n             = push_scan(lr, lc, cm);
      cfg_last_row  = lr[ROW_W-1:0];
      cfg_last_col  = lc[COL_W-1:0];
      cfg_col_major = cm;
      start         = 1'b1;
      abort         = 1'b0;
      advance       = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", int'(busy), 1);
   endtask

   // mode 0: advance every cycle, 1: random advance plus ignored start/cfg noise, 2: stall at (0,1)
   task automatic run_scan(input int lr, input int lc, input bit cm, input int mode);
      int n;
      int consumed = 0;
      int step     = 0;
      bit a;
      issue_start(lr, lc, cm, n);
      while (consumed < n) begin
         case (mode)
            0:       a = 1'b1;
            1:       a = ($urandom_range(0, 2) != 0);
            default: a = !(step == 1 || step == 2);
         endcase
         if (mode == 2 && !a) begin
            check("stall_hold_row", int'(row_idx), 0);
            check("stall_hold_col", int'(col_idx), 1);
         end
         if (mode == 1) begin
            start         = ($urandom_range(0, 3) == 0);
            cfg_last_row  = ROW_W'($urandom);
            cfg_last_col  = COL_W'($urandom);
            cfg_col_major = 1'($urandom);
         end
         advance = a;
         @(posedge clk);
         #1;
         if (a) consumed++;
         step++;
      end
      advance = 1'b0;
      start   = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst) begin
         if (expect_done) begin
            check("done_pulse", int'(done), 1);
            if (sb_q.size() > 0 && sb_q[0].is_done) void'(sb_q.pop_front());
            expect_done = 1'b0;
         end else if (done) begin
            check("unexpected_done", int'(done), 0);
         end
         if (busy) busy_cycles++;
         if (busy && advance && !abort) begin
            if (sb_q.size() == 0 || sb_q[0].is_done) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_elem: got (%0d,%0d), required no element", row_idx, col_idx);
            end else begin
               e = sb_q.pop_front();
               check("row_idx", int'(row_idx), e.r);
               check("col_idx", int'(col_idx), e.c);
               check("addr", int'(addr), e.a);
               check("row_last", int'(row_last), int'(e.rl));
               check("col_last", int'(col_last), int'(e.cl));
               if (sb_q.size() > 0 && sb_q[0].is_done) expect_done = 1'b1;
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int b0;
      rst           = 1'b0;
      start         = 1'b0;
      abort         = 1'b0;
      advance       = 1'b0;
      cfg_last_row  = '0;
      cfg_last_col  = '0;
      cfg_col_major = 1'b0;
      #3;
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_row", int'(row_idx), 0);
      check("reset_col", int'(col_idx), 0);
      check("reset_addr", int'(addr), 0);
      check("reset_row_last", int'(row_last), 0);
      check("reset_col_last", int'(col_last), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 2x3 row-major, then 2x3 column-major with busy-length check
      run_scan(1, 2, 1'b0, 0);
      b0 = busy_cycles;
      run_scan(1, 2, 1'b1, 0);
      check("colmajor_busy_cycles", busy_cycles - b0, 6);
      repeat (2) @(posedge clk);
      #1;

      // stall at (0,1) for two cycles
      run_scan(1, 2, 1'b0, 2);
      repeat (2) @(posedge clk);
      #1;

      // abort at element 3 (abort asserted together with advance)
      issue_start(1, 2, 1'b0, n);
      advance = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort   = 1'b0;
      advance = 1'b0;
      sb_q.delete();
      check("abort_busy", int'(busy), 0);
      check("abort_row", int'(row_idx), 0);
      check("abort_col", int'(col_idx), 0);
      check("abort_addr", int'(addr), 0);
      repeat (3) @(posedge clk);
      #1;
      run_scan(1, 1, 1'b0, 0);

      // clamped 8x1 request, back-to-back starts, 1x1 scan
      run_scan(7, 0, 1'b0, 0);
      run_scan(3, 4, 1'b1, 1);
      run_scan(0, 0, 1'b0, 0);
      run_scan(2, 127, 1'b0, 1);
      repeat (2) @(posedge clk);
      #1;

      // asynchronous reset while sitting at (1,1)
      issue_start(1, 2, 1'b0, n);
      advance = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      advance = 1'b0;
      check("pre_reset_row", int'(row_idx), 1);
      check("pre_reset_col", int'(col_idx), 1);
      #2;
      rst = 1'b0;
      #1;
      sb_q.delete();
      check("midrst_busy", int'(busy), 0);
      check("midrst_row", int'(row_idx), 0);
      check("midrst_col", int'(col_idx), 0);
      check("midrst_addr", int'(addr), 0);
      check("midrst_flags", int'({row_last, col_last, done}), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      run_scan(1, 2, 1'b0, 0);

      // randomized scans with random gaps
      repeat (20) begin
         run_scan($urandom_range(0, 7),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12),
                  1'($urandom_range(0, 1)), 1);
         if ($urandom_range(0, 1) != 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
